branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// - Decode-stage branch resolver for the 5-stage MIPS pipeline: signed compare of two
//   forwarded operands under an opcode-selected condition (beq/bne/blez/bgtz/bltz/bgez/bgezal).
// - Also holds a PC-indexed 2-bit pattern history table (PHT) and a D->E result register.
// - Keeps saturating branch / mispredict statistics counters.
// - Sits beside the D-stage register file read; outputs go to NPC, the E pipeline register
//   and the hazard unit.
// PARAMETERS
// - WIDTH      32  operand width in bits
// - PHT_DEPTH  16  PHT entry count; power of two, >=2
// - IDX_LSB    2   lowest PC bit used for the PHT index
// - CNT_WIDTH  16  statistics counter width
// PORTS
// - clk          in   1      rising-edge clock
// - reset        in   1      asynchronous, active-high
// - D_A          in   WIDTH  rs operand, already forwarded
// - D_B          in   WIDTH  rt operand, already forwarded
// - D_cmp_op     in   3      condition select (encoding below)
// - D_valid      in   1      a branch instruction is in D this cycle
// - D_pc         in   32     PC of the D instruction
// - stall        in   1      hazard stall; D is frozen, E receives a bubble
// - flush        in   1      kill D result; E receives a bubble
// - D_taken      out  1      combinational branch-taken
// - D_link       out  1      combinational; write $31 (bgezal)
// - D_pred_taken out  1      combinational PHT prediction for D_pc
// - E_valid      out  1      registered D_valid
// - E_taken      out  1      registered D_taken
// - E_link       out  1      registered D_link
// - E_mispredict out  1      registered; prediction differed from outcome
// - branch_cnt   out  CNT_WIDTH  resolved branches, saturating
// - mispred_cnt  out  CNT_WIDTH  mispredicted branches, saturating
// BEHAVIOUR
// - D_cmp_op encoding: 000 EQ A==B; 001 NE A!=B; 010 LEZ A<=0; 011 GTZ A>0;
//   100 LTZ A<0; 101 GEZ A>=0; 110 GEZAL A>=0 + link; 111 NONE, never taken.
// - Zero compares are two's-complement signed:
//   - sign bit = A[WIDTH-1]; zero = ~|A.
//   - LEZ = sign|zero; GTZ = ~sign&~zero.
//   - B is ignored for ops 010-111.
// - D_taken = D_valid & cond.
// - D_link = D_valid & (op==110), asserted whether or not the branch is taken.
// - Outputs do not depend on stall or flush.
// - PHT addressing:
//   - idx = D_pc[IDX_LSB +: log2(PHT_DEPTH)].
//   - D_pred_taken = PHT[idx][1], an asynchronous read of the current array.
// - Register update on posedge clk, priority order:
//   1. flush=1: E_valid/E_taken/E_link/E_mispredict <= 0; no PHT or counter update.
//   2. stall=1: same as flush (bubble into E); no PHT or counter update.
//   3. otherwise: E_* <= D_valid, D_taken, D_link, D_valid&(op!=111)&(D_pred_taken^D_taken).
// - "Resolve" = case 3 with D_valid=1 and op!=111. On a resolve:
//   - PHT[idx] +1 if D_taken, -1 if not; saturates at 11 and 00.
//   - branch_cnt +1, and mispred_cnt +1 if mispredict; both hold at all-ones.
// - Read/update in the same cycle: the prediction uses the pre-update PHT value. The new
//   value is visible from the next cycle.
// - Latency: D_* outputs in 0 cycles; E_*, PHT and counters 1 cycle.
// - Reset (asynchronous, any time, including mid-stall):
//   - E_* = 0; branch_cnt = mispred_cnt = 0.
//   - every PHT entry = 2'b01 (weakly not-taken).
//   - combinational outputs follow their inputs immediately.
// - No X propagation: D_taken, D_link and D_pred_taken are defined for every op value.
// TESTING
// - EQ: A=B=0x1234, op=000, valid=1, PC=0x3000 -> D_taken=1, pred=0.
//   Next cycle: E_taken=1, E_mispredict=1, PHT[0]=10, mispred_cnt=1.
// - Signed zero compares, A=0x80000000: LEZ taken, LTZ taken, GTZ not taken,
//   GEZ not taken. A=0: LEZ taken, GEZ taken, GTZ not taken.
// - GEZAL with A=-1: D_taken=0 and D_link=1. One cycle later: E_link=1, E_taken=0.
// - Saturation: PC=0x3004 taken 4 times -> PHT[1] goes 01,10,11,11 and D_pred_taken=1 from
//   the 2nd lookup onward. Then 1 not-taken -> 10, still predicted taken.
// - stall=1 (and separately flush=1) with valid taken branch -> E_valid=0, PHT and counters
//   unchanged. Both high at once -> same bubble.
// - Assert reset mid-sequence after 5 branches -> E_*=0 and counters=0 immediately,
//   PHT all 01. CNT_WIDTH=2 run of 5 branches -> branch_cnt holds at 3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : D-stage branch condition resolver with 2-bit PC-indexed PHT,
//            D->E result register and saturating branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int PHT_DEPTH = 16,
    parameter int IDX_LSB   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     D_A,
    input  logic [WIDTH-1:0]     D_B,
    input  logic [2:0]           D_cmp_op,
    input  logic                 D_valid,
    input  logic [31:0]          D_pc,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 D_taken,
    output logic                 D_link,
    output logic                 D_pred_taken,
    output logic                 E_valid,
    output logic                 E_taken,
    output logic                 E_link,
    output logic                 E_mispredict,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    localparam logic [2:0] c_op_eq    = 3'b000;
    localparam logic [2:0] c_op_ne    = 3'b001;
    localparam logic [2:0] c_op_lez   = 3'b010;
    localparam logic [2:0] c_op_gtz   = 3'b011;
    localparam logic [2:0] c_op_ltz   = 3'b100;
    localparam logic [2:0] c_op_gez   = 3'b101;
    localparam logic [2:0] c_op_gezal = 3'b110;
    localparam logic [2:0] c_op_none  = 3'b111;

    localparam logic [1:0] c_pht_init = 2'b01;

    logic                 w_sign;
    logic                 w_zero;
    logic                 w_cond;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_is_branch;
    logic                 w_mispredict;
    logic                 w_resolve;

    logic                 e_valid_q, e_valid_d;
    logic                 e_taken_q, e_taken_d;
    logic                 e_link_q, e_link_d;
    logic                 e_mispredict_q, e_mispredict_d;
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [1:0]           pht_q [PHT_DEPTH];
    logic [1:0]           pht_d [PHT_DEPTH];

    assign w_sign = D_A[WIDTH-1];
    assign w_zero = ~|D_A;

    always_comb begin
        w_cond = 1'b0;
        case (D_cmp_op)
            c_op_eq:    w_cond = (D_A == D_B);
            c_op_ne:    w_cond = (D_A != D_B);
            c_op_lez:   w_cond = w_sign | w_zero;
            c_op_gtz:   w_cond = ~w_sign & ~w_zero;
            c_op_ltz:   w_cond = w_sign;
            c_op_gez:   w_cond = ~w_sign;
            c_op_gezal: w_cond = ~w_sign;
            default:    w_cond = 1'b0;
        endcase
    end

    assign D_taken      = D_valid & w_cond;
    assign D_link       = D_valid & (D_cmp_op == c_op_gezal);
    assign w_idx        = D_pc[IDX_LSB +: IDX_W];
    // Prediction reads the registered table, so a same-cycle update is not visible yet.
    assign D_pred_taken = pht_q[w_idx][1];

    assign w_is_branch  = D_valid & (D_cmp_op != c_op_none);
    assign w_mispredict = w_is_branch & (D_pred_taken ^ D_taken);
    assign w_resolve    = w_is_branch & ~stall & ~flush;

    always_comb begin
        e_valid_d      = 1'b0;
        e_taken_d      = 1'b0;
        e_link_d       = 1'b0;
        e_mispredict_d = 1'b0;
        branch_cnt_d   = branch_cnt_q;
        mispred_cnt_d  = mispred_cnt_q;
        pht_d          = pht_q;

        if (!stall && !flush) begin
            e_valid_d      = D_valid;
            e_taken_d      = D_taken;
            e_link_d       = D_link;
            e_mispredict_d = w_mispredict;
        end

        if (w_resolve) begin
            if (D_taken) begin
                if (pht_q[w_idx] != 2'b11) pht_d[w_idx] = pht_q[w_idx] + 2'd1;
            end else begin
                if (pht_q[w_idx] != 2'b00) pht_d[w_idx] = pht_q[w_idx] - 2'd1;
            end
            if (branch_cnt_q != {CNT_WIDTH{1'b1}}) branch_cnt_d = branch_cnt_q + 1'b1;
            if (w_mispredict && (mispred_cnt_q != {CNT_WIDTH{1'b1}}))
                mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid_q      <= 1'b0;
            e_taken_q      <= 1'b0;
            e_link_q       <= 1'b0;
            e_mispredict_q <= 1'b0;
            branch_cnt_q   <= '0;
            mispred_cnt_q  <= '0;
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= c_pht_init;
        end else begin
            e_valid_q      <= e_valid_d;
            e_taken_q      <= e_taken_d;
            e_link_q       <= e_link_d;
            e_mispredict_q <= e_mispredict_d;
            branch_cnt_q   <= branch_cnt_d;
            mispred_cnt_q  <= mispred_cnt_d;
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= pht_d[i];
        end
    end

    assign E_valid      = e_valid_q;
    assign E_taken      = e_taken_q;
    assign E_link       = e_link_q;
    assign E_mispredict = e_mispredict_q;
    assign branch_cnt   = branch_cnt_q;
    assign mispred_cnt  = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Directed bench for branch_resolve_unit with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic [31:0] D_A, D_B, D_pc;
    logic [2:0]  D_cmp_op;
    logic        D_valid, stall, flush;

    logic        D_taken, D_link, D_pred_taken;
    logic        E_valid, E_taken, E_link, E_mispredict;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        D_taken2, D_link2, D_pred_taken2;
    logic        E_valid2, E_taken2, E_link2, E_mispredict2;
    logic [1:0]  branch_cnt2, mispred_cnt2;

    int vectors = 0;
    int miscompares = 0;
    logic run = 1'b0;

    branch_resolve_unit #(.WIDTH(32), .PHT_DEPTH(16), .IDX_LSB(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .D_A(D_A), .D_B(D_B), .D_cmp_op(D_cmp_op),
        .D_valid(D_valid), .D_pc(D_pc), .stall(stall), .flush(flush),
        .D_taken(D_taken), .D_link(D_link), .D_pred_taken(D_pred_taken),
        .E_valid(E_valid), .E_taken(E_taken), .E_link(E_link), .E_mispredict(E_mispredict),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve_unit #(.WIDTH(32), .PHT_DEPTH(16), .IDX_LSB(2), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .D_A(D_A), .D_B(D_B), .D_cmp_op(D_cmp_op),
        .D_valid(D_valid), .D_pc(D_pc), .stall(stall), .flush(flush),
        .D_taken(D_taken2), .D_link(D_link2), .D_pred_taken(D_pred_taken2),
        .E_valid(E_valid2), .E_taken(E_taken2), .E_link(E_link2), .E_mispredict(E_mispredict2),
        .branch_cnt(branch_cnt2), .mispred_cnt(mispred_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic f_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) <= 0;
            3'd3:    return $signed(a) > 0;
            3'd4:    return $signed(a) < 0;
            3'd5:    return $signed(a) >= 0;
            3'd6:    return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int f_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    int   m_pht [16];
    logic m_ev, m_et, m_el, m_em;
    int   m_bc, m_mc, m_bc2, m_mc2;

    logic exp_taken, exp_link, exp_pred, exp_branch, exp_mis;
    assign exp_taken  = D_valid && f_cond(D_cmp_op, D_A, D_B);
    assign exp_link   = D_valid && (D_cmp_op == 3'd6);
    assign exp_pred   = (m_pht[f_idx(D_pc)] >= 2);
    assign exp_branch = D_valid && (D_cmp_op != 3'd7);
    assign exp_mis    = exp_branch && (exp_pred != exp_taken);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_pht[i] <= 1;
            m_ev <= 1'b0; m_et <= 1'b0; m_el <= 1'b0; m_em <= 1'b0;
            m_bc <= 0; m_mc <= 0; m_bc2 <= 0; m_mc2 <= 0;
        end else if (stall || flush) begin
            m_ev <= 1'b0; m_et <= 1'b0; m_el <= 1'b0; m_em <= 1'b0;
        end else begin
            m_ev <= D_valid; m_et <= exp_taken; m_el <= exp_link; m_em <= exp_mis;
            if (exp_branch) begin
                if (exp_taken) m_pht[f_idx(D_pc)] <= (m_pht[f_idx(D_pc)] < 3) ? m_pht[f_idx(D_pc)] + 1 : 3;
                else           m_pht[f_idx(D_pc)] <= (m_pht[f_idx(D_pc)] > 0) ? m_pht[f_idx(D_pc)] - 1 : 0;
                m_bc  <= (m_bc  < 65535) ? m_bc  + 1 : m_bc;
                m_bc2 <= (m_bc2 < 3)     ? m_bc2 + 1 : m_bc2;
                if (exp_mis) begin
                    m_mc  <= (m_mc  < 65535) ? m_mc  + 1 : m_mc;
                    m_mc2 <= (m_mc2 < 3)     ? m_mc2 + 1 : m_mc2;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("D_taken", {31'b0, D_taken}, {31'b0, exp_taken});
            chk("D_link", {31'b0, D_link}, {31'b0, exp_link});
            chk("D_pred_taken", {31'b0, D_pred_taken}, {31'b0, exp_pred});
            chk("E_valid", {31'b0, E_valid}, {31'b0, m_ev});
            chk("E_taken", {31'b0, E_taken}, {31'b0, m_et});
            chk("E_link", {31'b0, E_link}, {31'b0, m_el});
            chk("E_mispredict", {31'b0, E_mispredict}, {31'b0, m_em});
            chk("branch_cnt", {16'b0, branch_cnt}, 32'(m_bc));
            chk("mispred_cnt", {16'b0, mispred_cnt}, 32'(m_mc));
            chk("branch_cnt_w2", {30'b0, branch_cnt2}, 32'(m_bc2));
            chk("mispred_cnt_w2", {30'b0, mispred_cnt2}, 32'(m_mc2));
            chk("D_pred_taken_w2", {31'b0, D_pred_taken2}, {31'b0, exp_pred});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic setd(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic st, input logic fl);
        D_valid = v; D_cmp_op = op; D_A = a; D_B = b; D_pc = pc; stall = st; flush = fl;
    endtask

    logic [3:0] sat_exp;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        setd(1'b0, 3'd7, 32'h0, 32'h0, 32'h3000, 1'b0, 1'b0);
        sat_exp = 4'b1110;
        @(posedge clk);
        run = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("reset E_valid", {31'b0, E_valid}, 32'd0);
        chk("reset branch_cnt", {16'b0, branch_cnt}, 32'd0);
        chk("reset pred", {31'b0, D_pred_taken}, 32'd0);

        // EQ taken at idx 0, predicted not-taken
        cyc(); setd(1'b1, 3'd0, 32'h1234, 32'h1234, 32'h3000, 1'b0, 1'b0); #1;
        chk("eq D_taken", {31'b0, D_taken}, 32'd1);
        chk("eq pred", {31'b0, D_pred_taken}, 32'd0);
        cyc(); setd(1'b0, 3'd7, 32'h0, 32'h0, 32'h3000, 1'b0, 1'b0); #1;
        chk("eq E_taken", {31'b0, E_taken}, 32'd1);
        chk("eq E_mispredict", {31'b0, E_mispredict}, 32'd1);
        chk("eq mispred_cnt", {16'b0, mispred_cnt}, 32'd1);
        chk("eq pht0 now 10", {31'b0, D_pred_taken}, 32'd1);

        // signed zero compares
        cyc(); setd(1'b1, 3'd2, 32'h8000_0000, 32'h0, 32'h3008, 1'b0, 1'b0); #1;
        chk("min LEZ", {31'b0, D_taken}, 32'd1);
        D_cmp_op = 3'd4; #1; chk("min LTZ", {31'b0, D_taken}, 32'd1);
        D_cmp_op = 3'd3; #1; chk("min GTZ", {31'b0, D_taken}, 32'd0);
        D_cmp_op = 3'd5; #1; chk("min GEZ", {31'b0, D_taken}, 32'd0);
        cyc(); setd(1'b1, 3'd2, 32'h0, 32'h0, 32'h3008, 1'b0, 1'b0); #1;
        chk("zero LEZ", {31'b0, D_taken}, 32'd1);
        D_cmp_op = 3'd5; #1; chk("zero GEZ", {31'b0, D_taken}, 32'd1);
        D_cmp_op = 3'd3; #1; chk("zero GTZ", {31'b0, D_taken}, 32'd0);

        // GEZAL not taken but links
        cyc(); setd(1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0, 32'h3008, 1'b0, 1'b0); #1;
        chk("gezal D_taken", {31'b0, D_taken}, 32'd0);
        chk("gezal D_link", {31'b0, D_link}, 32'd1);
        cyc(); setd(1'b0, 3'd7, 32'h0, 32'h0, 32'h3004, 1'b0, 1'b0); #1;
        chk("gezal E_link", {31'b0, E_link}, 32'd1);
        chk("gezal E_taken", {31'b0, E_taken}, 32'd0);

        // PHT saturation at idx 1
        for (int i = 0; i < 4; i++) begin
            cyc(); setd(1'b1, 3'd0, 32'h5, 32'h5, 32'h3004, 1'b0, 1'b0); #1;
            chk("sat pred", {31'b0, D_pred_taken}, {31'b0, sat_exp[i]});
        end
        cyc(); setd(1'b1, 3'd1, 32'h5, 32'h5, 32'h3004, 1'b0, 1'b0); #1;
        chk("nt pred", {31'b0, D_pred_taken}, 32'd1);
        cyc(); setd(1'b0, 3'd7, 32'h0, 32'h0, 32'h3004, 1'b0, 1'b0); #1;
        chk("after nt pred", {31'b0, D_pred_taken}, 32'd1);
        chk("branch_cnt 9", {16'b0, branch_cnt}, 32'd9);
        chk("mispred_cnt 3", {16'b0, mispred_cnt}, 32'd3);
        chk("w2 branch_cnt sat", {30'b0, branch_cnt2}, 32'd3);

        // stall, flush, both: bubble, no PHT or counter update
        for (int k = 1; k < 4; k++) begin
            cyc(); setd(1'b1, 3'd1, 32'h5, 32'h5, 32'h3004, k[0], k[1]);
            cyc(); setd(1'b0, 3'd7, 32'h0, 32'h0, 32'h3004, 1'b0, 1'b0); #1;
            chk("bubble E_valid", {31'b0, E_valid}, 32'd0);
            chk("bubble branch_cnt", {16'b0, branch_cnt}, 32'd9);
            chk("bubble pht", {31'b0, D_pred_taken}, 32'd1);
        end
        cyc(); setd(1'b1, 3'd1, 32'h5, 32'h5, 32'h3004, 1'b0, 1'b0);
        cyc(); setd(1'b0, 3'd7, 32'h0, 32'h0, 32'h3004, 1'b0, 1'b0); #1;
        chk("nt2 E_mispredict", {31'b0, E_mispredict}, 32'd1);
        chk("nt2 branch_cnt", {16'b0, branch_cnt}, 32'd10);
        chk("nt2 mispred_cnt", {16'b0, mispred_cnt}, 32'd4);
        chk("nt2 pred", {31'b0, D_pred_taken}, 32'd0);

        // five more branches, then asynchronous reset during a stall
        for (int i = 0; i < 5; i++) begin
            cyc(); setd(1'b1, 3'd0, 32'(i), 32'(i), 32'h3000, 1'b0, 1'b0);
        end
        cyc(); setd(1'b1, 3'd0, 32'h7, 32'h7, 32'h3000, 1'b1, 1'b0); #1;
        chk("pre-reset pred", {31'b0, D_pred_taken}, 32'd1);
        chk("pre-reset E_valid", {31'b0, E_valid}, 32'd1);
        reset = 1'b1; #1;
        chk("async E_valid", {31'b0, E_valid}, 32'd0);
        chk("async branch_cnt", {16'b0, branch_cnt}, 32'd0);
        chk("async mispred_cnt", {16'b0, mispred_cnt}, 32'd0);
        chk("async D_taken", {31'b0, D_taken}, 32'd1);
        chk("async pred", {31'b0, D_pred_taken}, 32'd0);
        cyc(); reset = 1'b0;
        setd(1'b0, 3'd7, 32'h0, 32'h0, 32'h3000, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            D_pc = 32'h3000 + 32'(4 * i); #1;
            chk("pht init", {31'b0, D_pred_taken}, 32'd0);
        end

        // five branches after reset: narrow counter holds at 3
        for (int i = 0; i < 5; i++) begin
            cyc(); setd(1'b1, 3'd5, 32'h1, 32'h0, 32'h3000 + 32'(8 * i), 1'b0, 1'b0);
        end
        cyc(); setd(1'b0, 3'd7, 32'h0, 32'h0, 32'h3000, 1'b0, 1'b0); #1;
        chk("post branch_cnt", {16'b0, branch_cnt}, 32'd5);
        chk("post w2 branch_cnt", {30'b0, branch_cnt2}, 32'd3);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
